// File: rtl/modport_bridge.sv
// ---------------------------------------------------------------------------
// modport_bridge
//
// AHB-Lite slave to APB master bridge. Each accepted AHB transfer becomes a
// single APB setup/enable access on a four-slave APB segment. The APB
// window starts at BASE_ADDR and holds four slots of 2**SLOT_BITS bytes each.
//
// Handshake: an AHB address phase is taken when Hreadyin = 1,
// Htrans = NONSEQ/SEQ and Haddr falls inside the window. Sampling happens
// only in IDLE, RENABLE or WENABLE, the states in which Hreadyout = 1.
// Hreadyout = 0 stretches the data phase: one wait state for reads and two
// for writes. Out-of-window, IDLE and BUSY transfers complete with OKAY and
// no wait state.
//
// Ports:
//   Hclk, Hresetn   clock, asynchronous active-low reset
//   Hwrite, Hreadyin, Htrans, Haddr, Hwdata   AHB master inputs
//   Prdata          read data from the selected APB slave
//   Hreadyout, Hresp, Hrdata                  AHB slave responses
//   Pselx, Paddr, Pwdata, Pwrite, Penable     registered APB outputs
// ---------------------------------------------------------------------------
module modport_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          SLOT_BITS = 26
) (
    input  logic        Hclk,
    input  logic        Hresetn,
    input  logic        Hwrite,
    input  logic        Hreadyin,
    input  logic [1:0]  Htrans,
    input  logic [31:0] Haddr,
    input  logic [31:0] Hwdata,
    input  logic [31:0] Prdata,
    output logic        Hreadyout,
    output logic [1:0]  Hresp,
    output logic [31:0] Hrdata,
    output logic [3:0]  Pselx,
    output logic [31:0] Paddr,
    output logic [31:0] Pwdata,
    output logic        Pwrite,
    output logic        Penable
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_RENABLE = 3'd2,
        ST_WWAIT   = 3'd3,
        ST_WRITE   = 3'd4,
        ST_WENABLE = 3'd5
    } state_t;

    // Current FSM state, visible to checkers bound into this scope.
    state_t state;

    // 34-bit arithmetic keeps the window end from wrapping for any base.
    localparam logic [33:0] BASE_EXT  = {2'b00, BASE_ADDR};
    localparam logic [33:0] SLOT_SIZE = 34'd1 << SLOT_BITS;

    logic [33:0] haddr_ext;
    logic [3:0]  sel_dec;
    logic        valid;

    // Registered address-phase information of the accepted transfer.
    logic [31:0] addr_q;
    logic        write_q;
    logic [3:0]  sel_q;

    assign haddr_ext = {2'b00, Haddr};

    // One comparator pair per slot; the slot hit is already one-hot and the
    // OR of all four is the in-window test.
    for (genvar i = 0; i < 4; i++) begin : g_dec
        localparam logic [33:0] LO = BASE_EXT + SLOT_SIZE * i;
        assign sel_dec[i] = (haddr_ext >= LO) && (haddr_ext < LO + SLOT_SIZE);
    end

    // Only Htrans[1] separates NONSEQ/SEQ from IDLE/BUSY.
    logic unused_htrans0;
    assign unused_htrans0 = Htrans[0];

    assign valid = Hreadyin && Htrans[1] && (|sel_dec);

    assign Hresp  = 2'b00;
    assign Hrdata = (state == ST_RENABLE) ? Prdata : 32'h0000_0000;

    // Single FSM block; every APB output is loaded together with the state
    // it belongs to, so outputs are registered and never glitch.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state     <= ST_IDLE;
            addr_q    <= 32'h0000_0000;
            write_q   <= 1'b0;
            sel_q     <= 4'b0000;
            Pselx     <= 4'b0000;
            Paddr     <= 32'h0000_0000;
            Pwdata    <= 32'h0000_0000;
            Pwrite    <= 1'b0;
            Penable   <= 1'b0;
            Hreadyout <= 1'b1;
        end else begin
            case (state)
                ST_IDLE, ST_RENABLE, ST_WENABLE: begin
                    Penable <= 1'b0;
                    if (valid) begin
                        addr_q  <= Haddr;
                        write_q <= Hwrite;
                        sel_q   <= sel_dec;
                        Hreadyout <= 1'b0;
                        if (!Hwrite) begin
                            // Read setup goes out straight away.
                            state  <= ST_READ;
                            Pselx  <= sel_dec;
                            Paddr  <= Haddr;
                            Pwrite <= 1'b0;
                        end else begin
                            // Write data arrives one cycle later.
                            state <= ST_WWAIT;
                            Pselx <= 4'b0000;
                        end
                    end else begin
                        state     <= ST_IDLE;
                        Pselx     <= 4'b0000;
                        Hreadyout <= 1'b1;
                    end
                end
                ST_READ: begin
                    state     <= ST_RENABLE;
                    Penable   <= 1'b1;
                    Hreadyout <= 1'b1;
                end
                ST_WWAIT: begin
                    state     <= ST_WRITE;
                    Pselx     <= sel_q;
                    Paddr     <= addr_q;
                    Pwdata    <= Hwdata;
                    Pwrite    <= write_q;
                    Penable   <= 1'b0;
                    Hreadyout <= 1'b0;
                end
                ST_WRITE: begin
                    state     <= ST_WENABLE;
                    Penable   <= 1'b1;
                    Hreadyout <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    Pselx     <= 4'b0000;
                    Penable   <= 1'b0;
                    Hreadyout <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_modport_bridge.sv
// ---------------------------------------------------------------------------
// tb_modport_bridge
//
// Self-checking bench for modport_bridge. A vector table plus a short random
// loop drive single transfers; hand-written sequences cover back-to-back
// transfers and reset during a write. Every completed APB access is popped
// from an expected queue and compared by a monitor.
// ---------------------------------------------------------------------------
module tb_modport_bridge;

    logic        Hclk;
    logic        Hresetn;
    logic        Hwrite;
    logic        Hreadyin;
    logic [1:0]  Htrans;
    logic [31:0] Haddr;
    logic [31:0] Hwdata;
    logic [31:0] Prdata;
    logic        Hreadyout;
    logic [1:0]  Hresp;
    logic [31:0] Hrdata;
    logic [3:0]  Pselx;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic        Pwrite;
    logic        Penable;

    modport_bridge dut (
        .Hclk      (Hclk),
        .Hresetn   (Hresetn),
        .Hwrite    (Hwrite),
        .Hreadyin  (Hreadyin),
        .Htrans    (Htrans),
        .Haddr     (Haddr),
        .Hwdata    (Hwdata),
        .Prdata    (Prdata),
        .Hreadyout (Hreadyout),
        .Hresp     (Hresp),
        .Hrdata    (Hrdata),
        .Pselx     (Pselx),
        .Paddr     (Paddr),
        .Pwdata    (Pwdata),
        .Pwrite    (Pwrite),
        .Penable   (Penable)
    );

    // ---------------- clock / reset ----------------
    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected APB access: {sel[3:0], write, addr[31:0], data[31:0]}.
    logic [68:0] exp_q[$];

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  trans;
        logic        rdy;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  exp_sel;
        logic        exp_act;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode, written from the address map.
    function automatic logic [3:0] model_sel(input logic [31:0] a);
        logic [31:0] off;
        if (a < 32'h8000_0000 || a >= 32'h9000_0000) return 4'b0000;
        off = a - 32'h8000_0000;
        return 4'b0001 << off[27:26];
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge Hclk) begin
        if (Hresetn && Penable) begin
            check("penable_with_psel", {31'd0, (Pselx != 4'b0000)}, 32'd1);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_access: sel %b addr %h with empty queue", Pselx, Paddr);
            end else begin
                logic [68:0] e;
                e = exp_q.pop_front();
                check("sb_sel",   {28'd0, Pselx}, {28'd0, e[68:65]});
                check("sb_write", {31'd0, Pwrite}, {31'd0, e[64]});
                check("sb_addr",  Paddr, e[63:32]);
                if (e[64]) check("sb_wdata", Pwdata, e[31:0]);
                else       check("sb_rdata", Hrdata, e[31:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic present(input logic [31:0] a, input logic wr, input logic [1:0] tr, input logic rdy);
        Hreadyin = rdy;
        Htrans   = tr;
        Haddr    = a;
        Hwrite   = wr;
    endtask

    task automatic run_vec(input vec_t v);
        @(posedge Hclk); #1;
        present(v.addr, v.wr, v.trans, v.rdy);
        if (v.exp_act) exp_q.push_back({v.exp_sel, v.wr, v.addr, v.wr ? v.wdata : v.rdata});
        @(posedge Hclk); #1;
        Htrans   = 2'b00;
        Hreadyin = 1'b1;
        Hwdata   = v.wdata;
        Prdata   = v.rdata;
        @(negedge Hclk);
        check("hresp", {30'd0, Hresp}, 32'd0);
        if (!v.exp_act) begin
            check("idle_psel", {28'd0, Pselx}, 32'd0);
            check("idle_ready", {31'd0, Hreadyout}, 32'd1);
            check("idle_penable", {31'd0, Penable}, 32'd0);
            @(negedge Hclk);
            check("idle_psel2", {28'd0, Pselx}, 32'd0);
            check("idle_ready2", {31'd0, Hreadyout}, 32'd1);
        end else if (!v.wr) begin
            check("rd_setup_psel", {28'd0, Pselx}, {28'd0, v.exp_sel});
            check("rd_setup_paddr", Paddr, v.addr);
            check("rd_setup_pwrite", {31'd0, Pwrite}, 32'd0);
            check("rd_setup_penable", {31'd0, Penable}, 32'd0);
            check("rd_setup_ready", {31'd0, Hreadyout}, 32'd0);
            @(negedge Hclk);
            check("rd_en_psel", {28'd0, Pselx}, {28'd0, v.exp_sel});
            check("rd_en_penable", {31'd0, Penable}, 32'd1);
            check("rd_en_ready", {31'd0, Hreadyout}, 32'd1);
            check("rd_hrdata", Hrdata, v.rdata);
        end else begin
            check("wr_wait_psel", {28'd0, Pselx}, 32'd0);
            check("wr_wait_ready", {31'd0, Hreadyout}, 32'd0);
            @(negedge Hclk);
            check("wr_setup_psel", {28'd0, Pselx}, {28'd0, v.exp_sel});
            check("wr_setup_paddr", Paddr, v.addr);
            check("wr_setup_pwrite", {31'd0, Pwrite}, 32'd1);
            check("wr_setup_pwdata", Pwdata, v.wdata);
            check("wr_setup_penable", {31'd0, Penable}, 32'd0);
            check("wr_setup_ready", {31'd0, Hreadyout}, 32'd0);
            @(negedge Hclk);
            check("wr_en_psel", {28'd0, Pselx}, {28'd0, v.exp_sel});
            check("wr_en_penable", {31'd0, Penable}, 32'd1);
            check("wr_en_ready", {31'd0, Hreadyout}, 32'd1);
            check("wr_hrdata_zero", Hrdata, 32'd0);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main test ----------------
    initial begin
        vec_t v;
        Hresetn  = 1'b0;
        present(32'h0, 1'b0, 2'b00, 1'b1);
        Hwdata   = 32'h0;
        Prdata   = 32'h0;

        //           addr          wr    trans  rdy   wdata          rdata          sel      act
        vecs[0]  = '{32'h8000_0010, 1'b0, 2'b10, 1'b1, 32'h0,         32'hDEAD_BEEF, 4'b0001, 1'b1};
        vecs[1]  = '{32'h8400_0004, 1'b1, 2'b10, 1'b1, 32'h1234_5678, 32'h0,         4'b0010, 1'b1};
        vecs[2]  = '{32'h8000_0000, 1'b0, 2'b10, 1'b1, 32'h0,         32'hA5A5_0001, 4'b0001, 1'b1};
        vecs[3]  = '{32'h8400_0000, 1'b0, 2'b10, 1'b1, 32'h0,         32'h5A5A_0002, 4'b0010, 1'b1};
        vecs[4]  = '{32'h8800_0000, 1'b1, 2'b10, 1'b1, 32'hCAFE_0003, 32'h0,         4'b0100, 1'b1};
        vecs[5]  = '{32'h8FFF_FFFC, 1'b0, 2'b10, 1'b1, 32'h0,         32'h0BAD_F00D, 4'b1000, 1'b1};
        vecs[6]  = '{32'h9000_0000, 1'b0, 2'b10, 1'b1, 32'h0,         32'h1111_1111, 4'b0000, 1'b0};
        vecs[7]  = '{32'h7FFF_FFFC, 1'b1, 2'b10, 1'b1, 32'h2222_2222, 32'h0,         4'b0000, 1'b0};
        vecs[8]  = '{32'h8000_0020, 1'b1, 2'b01, 1'b1, 32'h3333_3333, 32'h0,         4'b0000, 1'b0};
        vecs[9]  = '{32'h8400_0000, 1'b0, 2'b10, 1'b0, 32'h0,         32'h4444_4444, 4'b0000, 1'b0};
        vecs[10] = '{32'h8C00_0100, 1'b1, 2'b11, 1'b1, 32'h7777_8888, 32'h0,         4'b1000, 1'b1};

        // Reset state, checked while asserted and after release.
        repeat (3) @(posedge Hclk);
        @(negedge Hclk);
        check("rst_ready", {31'd0, Hreadyout}, 32'd1);
        check("rst_psel", {28'd0, Pselx}, 32'd0);
        check("rst_penable", {31'd0, Penable}, 32'd0);
        check("rst_hresp", {30'd0, Hresp}, 32'd0);
        check("rst_paddr", Paddr, 32'd0);
        check("rst_hrdata", Hrdata, 32'd0);
        Hresetn = 1'b1;
        @(negedge Hclk);
        check("post_rst_ready", {31'd0, Hreadyout}, 32'd1);
        check("post_rst_psel", {28'd0, Pselx}, 32'd0);

        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

        // Random in-window and near-window transfers, decoded by the model.
        for (int i = 0; i < 12; i++) begin
            v.addr    = 32'h7C00_0000 + ($urandom_range(0, 32'h17FF_FFFF) & 32'hFFFF_FFFC);
            v.wr      = 1'($urandom_range(0, 1));
            v.trans   = 2'b10;
            v.rdy     = 1'b1;
            v.wdata   = $urandom;
            v.rdata   = $urandom;
            v.exp_sel = model_sel(v.addr);
            v.exp_act = (v.exp_sel != 4'b0000);
            run_vec(v);
        end

        // Back-to-back: read, then a write presented during RENABLE.
        @(posedge Hclk); #1;
        present(32'h8000_0010, 1'b0, 2'b10, 1'b1);
        exp_q.push_back({4'b0001, 1'b0, 32'h8000_0010, 32'hFEED_0001});
        exp_q.push_back({4'b0100, 1'b1, 32'h8800_0008, 32'hB2B_0002});
        @(posedge Hclk); #1;
        Htrans = 2'b00;
        Prdata = 32'hFEED_0001;
        @(posedge Hclk); #1;
        check("b2b_renable_ready", {31'd0, Hreadyout}, 32'd1);
        present(32'h8800_0008, 1'b1, 2'b10, 1'b1);
        @(posedge Hclk); #1;
        Htrans = 2'b00;
        Hwdata = 32'hB2B_0002;
        @(negedge Hclk);
        check("b2b_wwait_psel", {28'd0, Pselx}, 32'd0);
        check("b2b_wwait_ready", {31'd0, Hreadyout}, 32'd0);
        @(negedge Hclk);
        check("b2b_setup_psel", {28'd0, Pselx}, 32'b0100);
        check("b2b_setup_pwrite", {31'd0, Pwrite}, 32'd1);
        check("b2b_setup_penable", {31'd0, Penable}, 32'd0);
        @(negedge Hclk);
        check("b2b_en_penable", {31'd0, Penable}, 32'd1);
        check("b2b_en_psel", {28'd0, Pselx}, 32'b0100);

        // Reset asserted during the WRITE setup cycle aborts the transfer.
        @(posedge Hclk); #1;
        present(32'h8000_0040, 1'b1, 2'b10, 1'b1);
        @(posedge Hclk); #1;
        Htrans = 2'b00;
        Hwdata = 32'hAAAA_5555;
        @(posedge Hclk);
        @(negedge Hclk);
        check("abort_setup_psel", {28'd0, Pselx}, 32'b0001);
        #2 Hresetn = 1'b0;
        #1;
        check("abort_psel", {28'd0, Pselx}, 32'd0);
        check("abort_penable", {31'd0, Penable}, 32'd0);
        check("abort_ready", {31'd0, Hreadyout}, 32'd1);
        check("abort_pwdata", Pwdata, 32'd0);
        check("abort_paddr", Paddr, 32'd0);
        check("abort_pwrite", {31'd0, Pwrite}, 32'd0);
        @(negedge Hclk);
        Hresetn = 1'b1;

        // A normal read after the abort.
        v = '{32'h8400_0100, 1'b0, 2'b10, 1'b1, 32'h0, 32'h600D_CAFE, 4'b0010, 1'b1};
        run_vec(v);

        // Drain: every expected access should have been seen.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge Hclk);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/modport_bridge.md
# modport_bridge

AHB-to-APB bridge: a single-slave AHB-Lite interface on the system bus side converts each accepted AHB transfer into one APB setup/enable access on a four-slave APB segment. Its APB-side signals (Pselx, Paddr, Pwdata, Pwrite, Penable, Prdata) drive and are sampled by the APB driver and monitor modports of the APB interface. All APB outputs are registered.

## Interface
Parameters:
- BASE_ADDR, 32'h8000_0000: start of APB window.
- SLOT_BITS, 26: address bits per APB slave (64 MB slots).

Ports:
- Hclk  in  1  clock, all logic on rising edge.
- Hresetn  in  1  asynchronous, active-low reset.
- Hwrite  in  1  AHB direction (1 = write).
- Hreadyin  in  1  AHB bus ready; address phase sampled only when 1.
- Htrans  in  2  AHB transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- Haddr  in  32  AHB address.
- Hwdata  in  32  AHB write data (data phase).
- Prdata  in  32  APB read data from selected slave.
- Hreadyout  out  1  AHB ready to master.
- Hresp  out  2  AHB response, constant 2'b00 (OKAY).
- Hrdata  out  32  AHB read data.
- Pselx  out  4  one-hot APB slave select.
- Paddr  out  32  APB address.
- Pwdata  out  32  APB write data.
- Pwrite  out  1  APB direction.
- Penable  out  1  APB enable strobe.

One clock; reset is asynchronous and active-low.

## Operation
- valid = Hreadyin & Htrans[1] & (BASE_ADDR <= Haddr < BASE_ADDR + 4·2^SLOT_BITS). BUSY/IDLE and out-of-window addresses are ignored: no APB access, OKAY response, Hreadyout stays 1.
- Decode: slot = (Haddr − BASE_ADDR) >> SLOT_BITS; slot 0/1/2/3 gives Pselx 0001/0010/0100/1000.
- On acceptance, Haddr, Hwrite and the decoded select are registered.
- FSM states: IDLE, READ, RENABLE, WWAIT, WRITE, WENABLE.
  - IDLE, RENABLE, WENABLE (accepting states): valid & !Hwrite → READ; valid & Hwrite → WWAIT; otherwise → IDLE.
  - READ → RENABLE.
  - WWAIT → WRITE; Hwdata is latched at the end of WWAIT.
  - WRITE → WENABLE.
- Outputs per state:
  - IDLE: Pselx = 0, Penable = 0, Hreadyout = 1.
  - READ: Pselx = sel, Paddr = addr, Pwrite = 0, Penable = 0, Hreadyout = 0.
  - RENABLE: same as READ but Penable = 1, Hreadyout = 1, Hrdata = Prdata (combinational pass-through).
  - WWAIT: Pselx = 0, Hreadyout = 0.
  - WRITE: Pselx = sel, Paddr = addr, Pwdata = latched data, Pwrite = 1, Penable = 0, Hreadyout = 0.
  - WENABLE: same as WRITE but Penable = 1, Hreadyout = 1.
- Paddr, Pwdata and Pwrite hold their last value when Pselx = 0.
- Hrdata is 0 outside RENABLE.

## Timing
- Reset (asynchronous assert, synchronous release): state = IDLE; Pselx, Paddr, Pwdata, Pwrite, Penable, Hrdata = 0; Hreadyout = 1; Hresp = 00.
- Read: address accepted at edge N. READ occupies cycle N..N+1 and RENABLE occupies N+1..N+2. Hrdata is valid and Hreadyout = 1 in cycle N+1, so there is 1 wait state.
- Write: address accepted at edge N. WWAIT, WRITE and WENABLE occupy cycles N, N+1 and N+2. Hreadyout = 1 in N+2, so there are 2 wait states.
- Back-to-back: a transfer presented during RENABLE or WENABLE is accepted at that state's closing edge, and its APB setup follows immediately with no IDLE gap.
- Penable is never 1 without Pselx ≠ 0. Pselx is stable across setup→enable.
- Reset asserted mid-transfer aborts it immediately and returns all outputs to their reset values.

## Test plan
- Reset: hold Hresetn = 0, then release → Hreadyout = 1, Pselx = 0, Penable = 0, Hresp = 00.
- Single read: Haddr = 32'h8000_0010, NONSEQ, Hwrite = 0. Next cycle Pselx = 0001, Paddr = 32'h8000_0010, Penable = 0. Following cycle Penable = 1; with Prdata = 32'hDEAD_BEEF, Hrdata = 32'hDEAD_BEEF and Hreadyout = 1.
- Single write: Haddr = 32'h8400_0004, Hwrite = 1, Hwdata = 32'h1234_5678. Expect Pselx = 0010, Pwrite = 1, Pwdata = 32'h1234_5678; Penable = 1 exactly one cycle after setup; Hreadyout low for 2 cycles.
- Decode sweep: addresses 0x8000_0000, 0x8400_0000, 0x8800_0000 and 0x8FFF_FFFC give Pselx 0001, 0010, 0100 and 1000 respectively. Address 0x9000_0000 → no Pselx, Hreadyout stays 1.
- Back-to-back: read then write to 0x8800_0008 presented during RENABLE → setup starts next cycle with Pselx = 0100, Pwrite = 1, after the WWAIT cycle.
- Htrans = BUSY or Hreadyin = 0 with an in-range address → FSM stays IDLE, no APB activity.
